multicycle_controller: RTL and testbench

Control unit for the next-generation multicycle ARM core. The core shares one memory port between instruction and data, so each instruction runs as a sequence of FSM states instead of completing in one cycle. The controller sequences fetch, decode, execute, memory and writeback, and holds the NZCV flags. It adds two features over the single-cycle control path: a memory ready handshake with a timeout, and a parametrised ALU-control width. It sits beside the multicycle datapath in the core top level and drives every datapath mux select and write enable.

---
 rtl/multicycle_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM with NZCV flags; ARM_CPU_BL_EN adds BL (PC+4 -> R14) in BRANCH.
// Latency: DP 4, LDR 5, STR 4, B 3 cycles with zero-wait memory; outputs are combinational from state.
// Backpressure: FETCH/MEMREAD/MEMWRITE stall on mem_ready; MEM_TIMEOUT wait cycles pulse bus_error and refetch.
module multicycle_controller #(
    parameter int ALU_CTL_W   = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           op,
    input  logic [3:0]           cond,
    input  logic [5:0]           funct,
    input  logic [3:0]           rd,
    input  logic [3:0]           alu_flags,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic [2:0]           reg_src,
    output logic [ALU_CTL_W-1:0] alu_ctl,
    output logic                 shift,
    output logic                 bus_error
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [3:0]       flags;
    logic             cond_ex;
    logic             cond_ok;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_mem;
    logic             timeout;
    logic [3:0]       cmd;
    logic             is_cmp;
    logic             cv_upd;
    logic [2:0]       alu_code;

    assign cmd     = funct[4:1];
    assign is_cmp  = (cmd == 4'b1010);
    assign cv_upd  = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
    assign is_mem  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    // mem_ready on the final allowed cycle wins over the timeout
    assign timeout = is_mem && !mem_ready && (wait_cnt == CNT_LAST);

    // flags = {N, Z, C, V}
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = flags[2];
            4'h1: cond_ok = ~flags[2];
            4'h2: cond_ok = flags[1];
            4'h3: cond_ok = ~flags[1];
            4'h4: cond_ok = flags[3];
            4'h5: cond_ok = ~flags[3];
            4'h6: cond_ok = flags[0];
            4'h7: cond_ok = ~flags[0];
            4'h8: cond_ok = flags[1] & ~flags[2];
            4'h9: cond_ok = ~flags[1] | flags[2];
            4'ha: cond_ok = (flags[3] == flags[0]);
            4'hb: cond_ok = (flags[3] != flags[0]);
            4'hc: cond_ok = ~flags[2] & (flags[3] == flags[0]);
            4'hd: cond_ok = flags[2] | (flags[3] != flags[0]);
            4'he: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_code = 3'd0;
        case (cmd)
            4'b0100: alu_code = 3'd0;
            4'b0010: alu_code = 3'd1;
            4'b0000: alu_code = 3'd2;
            4'b1100: alu_code = 3'd3;
            4'b1010: alu_code = 3'd1;
            4'b0001: if (ALU_CTL_W >= 3) alu_code = 3'd4;
            4'b1101: if (ALU_CTL_W >= 3) alu_code = 3'd5;
            default: alu_code = 3'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b01:   state_nxt = S_MEMADR;
                    2'b00:   state_nxt = funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_nxt = S_BRANCH;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
                        else if (timeout) state_nxt = S_FETCH;
            S_MEMWRITE: if (mem_ready || timeout) state_nxt = S_FETCH;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            flags    <= 4'b0000;
            cond_ex  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                cond_ex <= cond_ok;
            // a timeout re-enters FETCH, so it restarts the count like any other entry
            if (state_nxt != state || timeout)
                wait_cnt <= '0;
            else if (is_mem && !mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (state == S_ALUWB && cond_ex && (funct[0] || is_cmp)) begin
                flags[3:2] <= alu_flags[3:2];
                if (cv_upd)
                    flags[1:0] <= alu_flags[1:0];
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        imm_src    = 2'b00;
        reg_src    = 3'b000;
        alu_ctl    = '0;
        shift      = 1'b0;
        bus_error  = 1'b0;
        if (!reset) begin
            imm_src   = op;
            bus_error = timeout;
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b10;
                    reg_src[0] = 1'b1;
                end
                S_MEMADR: begin
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req    = 1'b1;
                    adr_src    = 1'b1;
                    reg_src[1] = 1'b1;
                    mem_write  = cond_ex & ~timeout;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = cond_ex;
                    pc_write   = cond_ex && (rd == 4'd15);
                end
                S_EXECR: begin
                    alu_ctl = ALU_CTL_W'(alu_code);
                    shift   = 1'b1;
                end
                S_EXECI: begin
                    alu_ctl   = ALU_CTL_W'(alu_code);
                    alu_src_b = 2'b01;
                end
                S_ALUWB: begin
                    // ALU keeps its operation so alu_flags reflect this instruction
                    alu_ctl    = ALU_CTL_W'(alu_code);
                    alu_src_b  = funct[5] ? 2'b01 : 2'b00;
                    result_src = 2'b00;
                    reg_write  = cond_ex & ~is_cmp;
                    pc_write   = cond_ex && !is_cmp && (rd == 4'd15);
                end
                S_BRANCH: begin
                    reg_src[0] = 1'b1;
                    alu_src_b  = 2'b01;
                    result_src = 2'b10;
                    pc_write   = cond_ex;
`ifdef ARM_CPU_BL_EN
                    if (funct[4]) begin
                        reg_write  = cond_ex;
                        reg_src[2] = 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output checks against hand-derived values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [3:0] cond;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] reg_src;
    logic [1:0] alu_ctl;
    logic       shift, bus_error;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .cond       (cond),
        .funct      (funct),
        .rd         (rd),
        .alu_flags  (alu_flags),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .reg_src    (reg_src),
        .alu_ctl    (alu_ctl),
        .shift      (shift),
        .bus_error  (bus_error)
    );

    logic [20:0] all_outs;
    assign all_outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src,
                       alu_src_a, alu_src_b, imm_src, reg_src, alu_ctl, shift, bus_error};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic cyc(input logic rdy, input logic [3:0] fl);
        @(negedge clk);
        mem_ready = rdy;
        alu_flags = fl;
        #1;
    endtask

    task automatic fetch(input logic [1:0] o, input logic [5:0] f, input logic [3:0] c, input logic [3:0] r);
        @(negedge clk);
        op = o; funct = f; cond = c; rd = r;
        mem_ready = 1'b1;
        alu_flags = 4'b0000;
        #1;
        chk("fetch_mem_req", mem_req, 1);
        chk("fetch_ir_write", ir_write, 1);
        chk("fetch_pc_write", pc_write, 1);
    endtask

    task automatic dp(input logic [5:0] f, input logic [3:0] c, input logic [3:0] r, input logic [3:0] fl,
                      input logic [1:0] exp_alu, input logic exp_rw, input logic exp_pcw);
        fetch(2'b00, f, c, r);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
        chk("exec_alu_ctl", alu_ctl, exp_alu);
        cyc(1'b1, fl);
        chk("aluwb_reg_write", reg_write, exp_rw);
        chk("aluwb_pc_write", pc_write, exp_pcw);
    endtask

    task automatic branch(input logic [3:0] c, input logic exp_pcw);
        fetch(2'b10, 6'b100000, c, 4'd0);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
        chk("branch_pc_write", pc_write, exp_pcw);
        chk("branch_reg_write", reg_write, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op = 2'b00; cond = 4'he; funct = 6'b0; rd = 4'd0;
        alu_flags = 4'b0; mem_ready = 1'b0;
        cyc(1'b0, 4'b0000);
        chk("reset_outs_0", all_outs, 0);
        cyc(1'b0, 4'b0000);
        chk("reset_outs_1", all_outs, 0);

        // ADD R1,R2,R3 right after reset release
        @(negedge clk);
        reset = 1'b0; op = 2'b00; funct = 6'b001000; cond = 4'he; rd = 4'd1; mem_ready = 1'b1;
        #1;
        chk("c1_mem_req", mem_req, 1);
        chk("c1_adr_src", adr_src, 0);
        chk("c1_alu_src_a", alu_src_a, 1);
        chk("c1_alu_src_b", alu_src_b, 2);
        chk("c1_result_src", result_src, 2);
        chk("c1_ir_write", ir_write, 1);
        chk("c1_pc_write", pc_write, 1);
        cyc(1'b1, 4'b0000);
        chk("c2_mem_req", mem_req, 0);
        chk("c2_reg_src", reg_src, 3'b001);
        chk("c2_reg_write", reg_write, 0);
        cyc(1'b1, 4'b0000);
        chk("c3_shift", shift, 1);
        chk("c3_alu_ctl", alu_ctl, 0);
        chk("c3_reg_write", reg_write, 0);
        cyc(1'b1, 4'b0000);
        chk("c4_reg_write", reg_write, 1);
        chk("c4_result_src", result_src, 0);
        chk("c4_pc_write", pc_write, 0);

        // LDR with three wait cycles in MEMREAD
        fetch(2'b01, 6'b011001, 4'he, 4'd3);
        cyc(1'b1, 4'b0000);
        chk("ldr_dec_mem_req", mem_req, 0);
        cyc(1'b1, 4'b0000);
        chk("ldr_adr_alu_src_a", alu_src_a, 0);
        chk("ldr_adr_alu_src_b", alu_src_b, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'b0000);
            chk("ldr_wait_mem_req", mem_req, 1);
            chk("ldr_wait_adr_src", adr_src, 1);
            chk("ldr_wait_reg_write", reg_write, 0);
        end
        cyc(1'b1, 4'b0000);
        chk("ldr_rdy_mem_req", mem_req, 1);
        cyc(1'b1, 4'b0000);
        chk("ldr_wb_reg_write", reg_write, 1);
        chk("ldr_wb_result_src", result_src, 1);
        chk("ldr_wb_mem_req", mem_req, 0);

        // SUBS sets Z, then BEQ taken and BNE not taken
        dp(6'b000101, 4'he, 4'd2, 4'b0100, 2'd1, 1'b1, 1'b0);
        branch(4'h0, 1'b1);
        chk("beq_alu_src_b", alu_src_b, 1);
        chk("beq_reg_src", reg_src, 3'b001);
        branch(4'h1, 1'b0);

        // Fetch timeout on the 15th wait cycle, then ready on the last allowed cycle
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b0, 4'b0000);
            chk("to_bus_error", bus_error, (k == 15));
            chk("to_ir_write", ir_write, 0);
            chk("to_pc_write", pc_write, 0);
        end
        for (int k = 1; k <= 14; k++) begin
            cyc(1'b0, 4'b0000);
            chk("to2_bus_error", bus_error, 0);
            chk("to2_mem_req", mem_req, 1);
        end

        // CMP (flags C=1) then ADD R15
        dp(6'b010101, 4'he, 4'd0, 4'b0010, 2'd1, 1'b0, 1'b0);
        chk("late_ready_bus_error", bus_error, 0);
        dp(6'b001000, 4'he, 4'd15, 4'b1111, 2'd0, 1'b1, 1'b1);
        branch(4'h2, 1'b1);
        branch(4'h0, 1'b0);

        // ORRS with NZCV=1111 updates only N and Z: flags become 1110
        dp(6'b011001, 4'he, 4'd4, 4'b1111, 2'd3, 1'b1, 1'b0);
        branch(4'h6, 1'b0);
        branch(4'h4, 1'b1);
        branch(4'h8, 1'b0);
        branch(4'hd, 1'b1);

        // ANDS with a false condition: no write, no flag update
        dp(6'b000001, 4'h1, 4'd5, 4'b0000, 2'd2, 1'b0, 1'b0);
        branch(4'h0, 1'b1);
        // EOR without the wide ALU control falls back to ADD
        dp(6'b000010, 4'he, 4'd6, 4'b0000, 2'd0, 1'b1, 1'b0);
        branch(4'hf, 1'b0);

        // BL
        fetch(2'b10, 6'b010000, 4'he, 4'd0);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
        chk("bl_pc_write", pc_write, 1);
`ifdef ARM_CPU_BL_EN
        chk("bl_reg_write", reg_write, 1);
        chk("bl_reg_src", reg_src, 3'b101);
`else
        chk("bl_reg_write", reg_write, 0);
        chk("bl_reg_src", reg_src, 3'b001);
`endif

        // STR zero-wait
        fetch(2'b01, 6'b011000, 4'he, 4'd7);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
        chk("str_mem_write", mem_write, 1);
        chk("str_reg_src", reg_src, 3'b010);
        chk("str_adr_src", adr_src, 1);

        // STR timing out in MEMWRITE
        fetch(2'b01, 6'b011000, 4'he, 4'd7);
        chk("str2_adr_src", adr_src, 0);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b0, 4'b0000);
            chk("strto_mem_write", mem_write, (k < 15));
            chk("strto_bus_error", bus_error, (k == 15));
            chk("strto_mem_req", mem_req, 1);
        end

        // Reset in the middle of an ADD, then flags read back as cleared
        fetch(2'b00, 6'b001000, 4'he, 4'd1);
        cyc(1'b1, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_outs", all_outs, 0);
        cyc(1'b0, 4'b0000);
        chk("midrst_outs2", all_outs, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postrst_mem_req", mem_req, 1);
        chk("postrst_adr_src", adr_src, 0);
        chk("postrst_shift", shift, 0);
        branch(4'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
